// File: rtl/cond_exec_stage_if.sv
// Decode-to-execute control bus for the conditional-execution stage.
// The master drives decode-side controls and observes the gated E-stage outputs.
interface cond_exec_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             StallE;
  logic             FlushE;
  logic [3:0]       CondD;
  logic [1:0]       FlagWD;
  logic             PCSD;
  logic             RegWD;
  logic             MemWD;
  logic             MemtoRegD;
  logic             ALUSrcD;
  logic             NoWriteD;
  logic [1:0]       ALUControlD;
  logic [3:0]       ALUFlags;

  logic             PCSrcE;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             MemtoRegE;
  logic             ALUSrcE;
  logic [1:0]       ALUControlE;
  logic             CondExE;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] AnnulCnt;

  modport master (
    output StallE, FlushE, CondD, FlagWD, PCSD, RegWD, MemWD, MemtoRegD,
           ALUSrcD, NoWriteD, ALUControlD, ALUFlags,
    input  PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, ALUControlE,
           CondExE, Flags, ExecCnt, AnnulCnt
  );

  modport slave (
    input  StallE, FlushE, CondD, FlagWD, PCSD, RegWD, MemWD, MemtoRegD,
           ALUSrcD, NoWriteD, ALUControlD, ALUFlags,
    output PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, ALUControlE,
           CondExE, Flags, ExecCnt, AnnulCnt
  );
endinterface

// File: rtl/cond_exec_stage.sv
// Execute-stage control register and conditional-execution unit: evaluates the
// condition field against committed NZCV, gates side effects, owns flags and retire counters.
module cond_exec_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  cond_exec_stage_if.slave bus
);

  localparam int unsigned NZCV_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic [1:0] flag_we;
    logic       pcs;
    logic       reg_we;
    logic       mem_we;
    logic       mem_to_reg;
    logic       alu_src;
    logic       no_write;
    logic [1:0] alu_ctl;
  } ereg_t;

  ereg_t              e_q, e_d;
  logic [NZCV_W-1:0]  flags_q, flags_d;
  logic [CNT_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0]   annul_cnt_q, annul_cnt_d;

  logic cond_pass_c;
  logic go_c;
  logic retire_c;

  // ARM condition-code evaluation on {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [NZCV_W-1:0] nzcv);
    logic n, z, c, v;
    logic pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  // Condition always sees the committed (pre-update) flags
  always_comb begin
    cond_pass_c = cond_eval(e_q.cond, flags_q);
    go_c        = e_q.valid & ~bus.StallE & cond_pass_c;
    retire_c    = e_q.valid & ~bus.StallE;
  end

  // E register next state: flush beats stall
  always_comb begin
    e_d = e_q;
    if (bus.FlushE) begin
      e_d = '0;
    end else if (!bus.StallE) begin
      e_d.valid      = 1'b1;
      e_d.cond       = bus.CondD;
      e_d.flag_we    = bus.FlagWD;
      e_d.pcs        = bus.PCSD;
      e_d.reg_we     = bus.RegWD;
      e_d.mem_we     = bus.MemWD;
      e_d.mem_to_reg = bus.MemtoRegD;
      e_d.alu_src    = bus.ALUSrcD;
      e_d.no_write   = bus.NoWriteD;
      e_d.alu_ctl    = bus.ALUControlD;
    end
  end

  // Split flag write: NZ and CV enables are independent
  always_comb begin
    flags_d = flags_q;
    if (go_c && e_q.flag_we[1]) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
    end
    if (go_c && e_q.flag_we[0]) begin
      flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  // Saturating retire counters
  always_comb begin
    exec_cnt_d  = exec_cnt_q;
    annul_cnt_d = annul_cnt_q;
    if (retire_c) begin
      if (cond_pass_c) begin
        if (exec_cnt_q != CNT_MAX) begin
          exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
      end else begin
        if (annul_cnt_q != CNT_MAX) begin
          annul_cnt_d = annul_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q         <= '0;
      flags_q     <= '0;
      exec_cnt_q  <= '0;
      annul_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      flags_q     <= flags_d;
      exec_cnt_q  <= exec_cnt_d;
      annul_cnt_q <= annul_cnt_d;
    end
  end

  assign bus.PCSrcE      = e_q.pcs & go_c;
  assign bus.RegWriteE   = e_q.reg_we & ~e_q.no_write & go_c;
  assign bus.MemWriteE   = e_q.mem_we & go_c;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.ALUControlE = e_q.alu_ctl;
  assign bus.CondExE     = e_q.valid & cond_pass_c;
  assign bus.Flags       = flags_q;
  assign bus.ExecCnt     = exec_cnt_q;
  assign bus.AnnulCnt    = annul_cnt_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed vector table, model-checked condition sweep,
// and async reset; a CNT_W=2 copy shares the stimulus to exercise counter saturation.
module tb_cond_exec_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_exec_stage_if #(.CNT_W(16)) ifc ();
  cond_exec_stage_if #(.CNT_W(2))  ifs ();

  assign ifs.StallE      = ifc.StallE;
  assign ifs.FlushE      = ifc.FlushE;
  assign ifs.CondD       = ifc.CondD;
  assign ifs.FlagWD      = ifc.FlagWD;
  assign ifs.PCSD        = ifc.PCSD;
  assign ifs.RegWD       = ifc.RegWD;
  assign ifs.MemWD       = ifc.MemWD;
  assign ifs.MemtoRegD   = ifc.MemtoRegD;
  assign ifs.ALUSrcD     = ifc.ALUSrcD;
  assign ifs.NoWriteD    = ifc.NoWriteD;
  assign ifs.ALUControlD = ifc.ALUControlD;
  assign ifs.ALUFlags    = ifc.ALUFlags;

  cond_exec_stage #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(ifc.slave));
  cond_exec_stage #(.CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flagw;
    logic       pcs, regw, memw, mtr, alusrc, nowr;
    logic [1:0] aluctl;
  } din_t;

  typedef struct packed {
    logic        pc, rw, mw, mtr, as;
    logic [1:0]  ac;
    logic        cx;
    logic [3:0]  fg;
    logic [15:0] ex, an;
    logic [1:0]  sex, san;
  } exp_t;

  typedef struct packed {
    din_t       d;
    logic [3:0] af;
    logic       st, fl;
    exp_t       e;
  } rec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  din_t       m_e;
  logic       m_v;
  logic [3:0] m_fg;
  int         m_ex, m_an, m_sex, m_san;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic din_t mk_in(input int cond, flagw, pcs, regw, memw, mtr, alusrc, nowr, aluctl);
    din_t d;
    d.cond = 4'(cond);   d.flagw = 2'(flagw);  d.pcs = 1'(pcs);
    d.regw = 1'(regw);   d.memw = 1'(memw);    d.mtr = 1'(mtr);
    d.alusrc = 1'(alusrc); d.nowr = 1'(nowr);  d.aluctl = 2'(aluctl);
    return d;
  endfunction

  function automatic rec_t row(input din_t d, input int af, st, fl, pc, rw, mw, mtr, as, ac, cx, fg, ex, an);
    rec_t r;
    r.d = d; r.af = 4'(af); r.st = 1'(st); r.fl = 1'(fl);
    r.e.pc = 1'(pc); r.e.rw = 1'(rw); r.e.mw = 1'(mw); r.e.mtr = 1'(mtr); r.e.as = 1'(as);
    r.e.ac = 2'(ac); r.e.cx = 1'(cx); r.e.fg = 4'(fg);
    r.e.ex = 16'(ex); r.e.an = 16'(an);
    r.e.sex = 2'(sat(ex, 3)); r.e.san = 2'(sat(an, 3));
    return r;
  endfunction

  // Reference condition: base test on cond[3:1], inverted by cond[0]
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] & ~f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = ~f[2] & (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  function automatic void model_clear();
    m_e = '0; m_v = 1'b0; m_fg = 4'h0; m_ex = 0; m_an = 0; m_sex = 0; m_san = 0;
  endfunction

  function automatic exp_t model_exp(input logic st);
    exp_t e;
    logic pass, go;
    pass = ref_cond(m_e.cond, m_fg);
    go   = m_v & ~st & pass;
    e.pc = m_e.pcs & go;
    e.rw = m_e.regw & ~m_e.nowr & go;
    e.mw = m_e.memw & go;
    e.mtr = m_e.mtr; e.as = m_e.alusrc; e.ac = m_e.aluctl;
    e.cx = m_v & pass;
    e.fg = m_fg;
    e.ex = 16'(m_ex); e.an = 16'(m_an);
    e.sex = 2'(m_sex); e.san = 2'(m_san);
    return e;
  endfunction

  function automatic void model_update(input din_t d, input logic [3:0] af, input logic st, input logic fl);
    logic pass, go;
    pass = ref_cond(m_e.cond, m_fg);
    go   = m_v & ~st & pass;
    if (go && m_e.flagw[1]) m_fg[3:2] = af[3:2];
    if (go && m_e.flagw[0]) m_fg[1:0] = af[1:0];
    if (m_v && !st) begin
      if (pass) begin m_ex = sat(m_ex + 1, 65535); m_sex = sat(m_sex + 1, 3); end
      else      begin m_an = sat(m_an + 1, 65535); m_san = sat(m_san + 1, 3); end
    end
    if (fl) begin m_v = 1'b0; m_e = '0; end
    else if (!st) begin m_v = 1'b1; m_e = d; end
  endfunction

  function automatic void chk(input string tag, input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endfunction

  task automatic drive(input din_t d, input logic [3:0] af, input logic st, input logic fl);
    ifc.CondD = d.cond;   ifc.FlagWD = d.flagw;   ifc.PCSD = d.pcs;
    ifc.RegWD = d.regw;   ifc.MemWD = d.memw;     ifc.MemtoRegD = d.mtr;
    ifc.ALUSrcD = d.alusrc; ifc.NoWriteD = d.nowr; ifc.ALUControlD = d.aluctl;
    ifc.ALUFlags = af;    ifc.StallE = st;        ifc.FlushE = fl;
  endtask

  task automatic check(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk(tag, "PCSrcE",      16'(ifc.PCSrcE),      16'(e.pc));
    chk(tag, "RegWriteE",   16'(ifc.RegWriteE),   16'(e.rw));
    chk(tag, "MemWriteE",   16'(ifc.MemWriteE),   16'(e.mw));
    chk(tag, "MemtoRegE",   16'(ifc.MemtoRegE),   16'(e.mtr));
    chk(tag, "ALUSrcE",     16'(ifc.ALUSrcE),     16'(e.as));
    chk(tag, "ALUControlE", 16'(ifc.ALUControlE), 16'(e.ac));
    chk(tag, "CondExE",     16'(ifc.CondExE),     16'(e.cx));
    chk(tag, "Flags",       16'(ifc.Flags),       16'(e.fg));
    chk(tag, "ExecCnt",     ifc.ExecCnt,          e.ex);
    chk(tag, "AnnulCnt",    ifc.AnnulCnt,         e.an);
    chk(tag, "ExecCnt_w2",  16'(ifs.ExecCnt),     16'(e.sex));
    chk(tag, "AnnulCnt_w2", 16'(ifs.AnnulCnt),    16'(e.san));
  endtask

  task automatic model_step(input din_t d, input logic [3:0] af, input logic st, input logic fl, input string tag);
    @(negedge clk);
    drive(d, af, st, fl);
    sb.push_back(model_exp(st));
    #1;
    check(tag);
    model_update(d, af, st, fl);
  endtask

  // Flush held during reset so the first edge after release loads a bubble
  task automatic do_reset();
    exp_t z;
    z = '0;
    @(negedge clk);
    reset = 1'b1;
    drive('0, 4'h0, 1'b0, 1'b1);
    #1;
    sb.push_back(z);
    check("reset");
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  rec_t vec[23];

  initial begin
    din_t add_i, cmp_i, part_i, beq_i, bne_i, ge_i, lt_i, gt_i, le_i, nv_i, str_i, ldr_i, nop_i, t_i;
    exp_t z;
    logic [3:0] cc;
    logic st, fl;

    reset = 1'b1;
    drive('0, 4'h0, 1'b0, 1'b1);
    model_clear();

    add_i  = mk_in(14, 0, 0, 1, 0, 0, 0, 0, 0);
    cmp_i  = mk_in(14, 3, 0, 1, 0, 0, 0, 1, 1);
    part_i = mk_in(14, 2, 0, 1, 0, 0, 0, 1, 1);
    beq_i  = mk_in(0,  0, 1, 0, 0, 0, 0, 0, 0);
    bne_i  = mk_in(1,  0, 1, 0, 0, 0, 0, 0, 0);
    ge_i   = mk_in(10, 0, 0, 1, 0, 0, 0, 0, 0);
    lt_i   = mk_in(11, 0, 0, 1, 0, 0, 0, 0, 0);
    gt_i   = mk_in(12, 0, 0, 1, 0, 0, 0, 0, 0);
    le_i   = mk_in(13, 0, 0, 1, 0, 0, 0, 0, 0);
    nv_i   = mk_in(15, 3, 0, 1, 0, 0, 0, 0, 0);
    str_i  = mk_in(14, 0, 0, 0, 1, 0, 1, 0, 0);
    ldr_i  = mk_in(14, 0, 0, 1, 0, 1, 1, 0, 0);
    nop_i  = '0;

    // Row observes the instruction loaded on the previous edge; af/st/fl act on it now
    //               d       af st fl pc rw mw mt as ac cx fg   ex an
    vec[0]  = row(add_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0);
    vec[1]  = row(cmp_i,   0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0,   0, 0);
    vec[2]  = row(beq_i,   4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   1, 0);
    vec[3]  = row(bne_i,   0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4,   2, 0);
    vec[4]  = row(cmp_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4,   3, 0);
    vec[5]  = row(ge_i,    9, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4,   3, 1);
    vec[6]  = row(lt_i,    0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 9,   4, 1);
    vec[7]  = row(cmp_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9,   5, 1);
    vec[8]  = row(gt_i,    8, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9,   5, 2);
    vec[9]  = row(cmp_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8,   6, 2);
    vec[10] = row(le_i,    4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8,   6, 3);
    vec[11] = row(cmp_i,   0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4,   7, 3);
    vec[12] = row(part_i,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4,   8, 3);
    vec[13] = row(nv_i,   15, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   9, 3);
    vec[14] = row(str_i,  15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 10, 3);
    vec[15] = row(ldr_i,   0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 12, 10, 4);
    vec[16] = row(ldr_i,   0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 12, 10, 4);
    vec[17] = row(ldr_i,   0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 12, 10, 4);
    vec[18] = row(ldr_i,   0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 12, 10, 4);
    vec[19] = row(str_i,   0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 12, 11, 4);
    vec[20] = row(add_i,   0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 12, 12, 4);
    vec[21] = row(nop_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 4);
    vec[22] = row(nop_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 12, 4);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vec[i].d, vec[i].af, vec[i].st, vec[i].fl);
      sb.push_back(vec[i].e);
      #1;
      check($sformatf("vec%0d", i));
    end

    // All 16 conditions against all 16 flag values, with sporadic stall/flush
    do_reset();
    for (int f = 0; f < 16; f++) begin
      model_step(cmp_i, 4'($urandom_range(0, 15)), 1'b0, 1'b0, $sformatf("sw_set%0d", f));
      for (int c = 0; c < 16; c++) begin
        cc  = 4'(c);
        t_i = mk_in(c, 0, int'(cc[1]), 1, int'(cc[0]), 0, 0, 0, int'(cc[3:2]));
        st  = ($urandom_range(0, 5) == 0);
        fl  = ($urandom_range(0, 40) == 0);
        model_step(t_i, (c == 0) ? 4'(f) : 4'($urandom_range(0, 15)), st, fl,
                   $sformatf("sw_f%0d_c%0d", f, c));
      end
      model_step(t_i, 4'h0, 1'b0, 1'b0, $sformatf("sw_tail%0d", f));
    end

    // Async reset mid-cycle while an instruction is held stalled
    model_step(str_i, 4'h0, 1'b0, 1'b0, "pre_rst0");
    model_step(add_i, 4'h0, 1'b1, 1'b0, "pre_rst1");
    @(negedge clk);
    drive(add_i, 4'h0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    z = '0;
    sb.push_back(z);
    check("async_reset");
    ifc.FlushE = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    model_step(add_i, 4'h0, 1'b0, 1'b0, "post_rst0");
    model_step(nop_i, 4'h0, 1'b0, 1'b0, "post_rst1");
    model_step(nop_i, 4'h0, 1'b0, 1'b0, "post_rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
